cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_SRC, 3, number of execution result sources (ALU0, ALU1, LSU).
- CDB_W, 2, number of CDB broadcast lanes per cycle.
- PHYS_W, 6, physical register tag width.
- ROB_W, 6, ROB tag width.
- FIFO_DEPTH, 4, result FIFO entries per source (power of 2).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high.
- flush, input, 1, synchronous pipeline flush.
- src_valid, input, N_SRC, result offered by each source.
- src_ready, output, N_SRC, source FIFO can accept.
- src_tag, input, N_SRC x PHYS_W, destination physical tag.
- src_value, input, N_SRC x 64, result value.
- src_rob_tag, input, N_SRC x ROB_W, ROB tag.
- cdb_valid, output, CDB_W, lane broadcast valid.
- cdb_tag, output, CDB_W x PHYS_W, broadcast tag.
- cdb_value, output, CDB_W x 64, broadcast value.
- cdb_rob_tag, output, CDB_W x ROB_W, broadcast ROB tag (for ROB completion).

Function
REQ-003 Each source SHALL own one FIFO_DEPTH-entry FIFO of {tag, value, rob_tag}, with read/write pointers that wrap modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
REQ-004 A push SHALL occur on a rising edge when src_valid[i] and src_ready[i] are both high.
REQ-005 src_ready[i] SHALL equal (count[i] < FIFO_DEPTH), computed from registered count only; a same-cycle pop SHALL NOT raise ready.
REQ-006 A simultaneous push and pop on one FIFO SHALL leave its count unchanged; a push while full is impossible by construction.
REQ-007 Each cycle, the arbiter SHALL scan sources circularly starting at rr_ptr and grant the first up to CDB_W non-empty FIFOs, one lane per source.
REQ-008 The first grant SHALL go to lane 0 and the second to lane 1; unused lanes SHALL drive cdb_valid=0 with tag, value and rob_tag = 0.
REQ-009 Each granted FIFO SHALL pop its head on the same edge that the output registers load it.
REQ-010 On any grant, rr_ptr SHALL advance to (last granted index + 1) mod N_SRC; with no grant, rr_ptr SHALL hold.
REQ-011 All cdb_* outputs SHALL be registered; without bypass, a result pushed at edge N SHALL appear on the CDB at the earliest in the cycle after edge N+1.
REQ-012 flush SHALL, at the next edge, empty all FIFOs, reset rr_ptr to 0, and clear cdb_valid; pushes and grants in the flush cycle SHALL be discarded.
REQ-013 flush SHALL take priority over push, pop and bypass in the same cycle.
REQ-014 When all FIFOs are empty and no bypass applies, cdb_valid SHALL be 0 in the following cycle.

Reset
REQ-015 On reset assertion, the block SHALL asynchronously clear all FIFO pointers and counts, set rr_ptr=0, and drive cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_rob_tag=0; src_ready SHALL then read all ones.
REQ-016 Reset asserted mid-operation SHALL discard all buffered results, with no partial broadcast after release.

Configuration
REQ-017 When macro CDB_ARBITER_BYPASS_EN is defined, a source whose FIFO is empty and which is offering a valid input SHALL count as non-empty for arbitration.
- If granted, its input SHALL load the output register directly at that edge without being written to the FIFO, giving 1-cycle latency.
- If not granted, the input SHALL be pushed normally.
REQ-018 When CDB_ARBITER_BYPASS_EN is undefined, no bypass path SHALL exist and every result SHALL pass through its FIFO.

Verification
REQ-019 Reset, then push src0 {tag=5, value=0x1234, rob=3} at edge 1 -> cdb_valid=01 with tag 5, value 0x1234, rob 3 after edge 2; with BYPASS_EN, this occurs after edge 1.
REQ-020 Push all 3 sources in one cycle with rr_ptr=0 -> lanes carry src0 and src1 first, then src2 on lane 0 the next cycle; rr_ptr ends at 0.
REQ-021 Hold src1 valid for 6 cycles while the other sources stall and there is no pop contention -> src1_ready falls only after the 4th buffered entry; no entry is lost or duplicated; order is preserved.
REQ-022 Keep FIFOs 1 and 2 continuously non-empty for 10 cycles -> grants alternate fairly and each source is broadcast at least once every 2 cycles.
REQ-023 Assert flush with 2 entries buffered per source -> cdb_valid=00 next cycle, all src_ready=1, and none of the buffered tags is ever broadcast.
REQ-024 Assert reset asynchronously mid-cycle while cdb_valid=11 -> outputs are zero immediately, before the next clock edge.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result-source and CDB broadcast bundle for cdb_arbiter.
// The slave modport is the arbiter; the master modport is the source/consumer side.
interface cdb_arbiter_if #(
   parameter int N_SRC  = 3,
   parameter int CDB_W  = 2,
   parameter int PHYS_W = 6,
   parameter int ROB_W  = 6
);
   logic [N_SRC-1:0]             src_valid;
   logic [N_SRC-1:0]             src_ready;
   logic [N_SRC-1:0][PHYS_W-1:0] src_tag;
   logic [N_SRC-1:0][63:0]       src_value;
   logic [N_SRC-1:0][ROB_W-1:0]  src_rob_tag;
   logic [CDB_W-1:0]             cdb_valid;
   logic [CDB_W-1:0][PHYS_W-1:0] cdb_tag;
   logic [CDB_W-1:0][63:0]       cdb_value;
   logic [CDB_W-1:0][ROB_W-1:0]  cdb_rob_tag;

   modport master (
      output src_valid, src_tag, src_value, src_rob_tag,
      input  src_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
   );
   modport slave (
      input  src_valid, src_tag, src_value, src_rob_tag,
      output src_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-source result FIFOs feeding a round-robin, CDB_W-lane common data bus.
// Define CDB_ARBITER_BYPASS_EN to let an empty FIFO's live input win arbitration directly.
module cdb_arbiter_fifo #(
   parameter int W     = 76,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         ready
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [CW-1:0]           count;

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign ready = (count != CW'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end
endmodule

module cdb_arbiter #(
   parameter int N_SRC      = 3,
   parameter int CDB_W      = 2,
   parameter int PHYS_W     = 6,
   parameter int ROB_W      = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   cdb_arbiter_if.slave bus
);
   localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef struct packed {
      logic [PHYS_W-1:0] tag;
      logic [63:0]       value;
      logic [ROB_W-1:0]  rob;
   } res_t;

   res_t [N_SRC-1:0] word, head, eff;
   res_t [CDB_W-1:0] lane_word, out_q;
   logic [N_SRC-1:0] empty, ready, push, pop, grant, cand;
   logic [CDB_W-1:0] lane_act, valid_q;
   logic [SW-1:0]    rr_ptr, rr_next;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      assign word[g] = '{tag: bus.src_tag[g], value: bus.src_value[g], rob: bus.src_rob_tag[g]};
      cdb_arbiter_fifo #(.W($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk(clk), .reset(reset), .flush(flush),
         .push(push[g]), .pop(pop[g]), .din(word[g]), .dout(head[g]),
         .empty(empty[g]), .ready(ready[g])
      );
`ifdef CDB_ARBITER_BYPASS_EN
      assign eff[g] = empty[g] ? word[g] : head[g];
`else
      assign eff[g] = head[g];
`endif
   end

`ifdef CDB_ARBITER_BYPASS_EN
   // A granted empty source is consumed straight from its input, so it must not also be queued.
   assign cand = ~empty | bus.src_valid;
   assign push = bus.src_valid & ready & ~(grant & empty);
`else
   assign cand = ~empty;
   assign push = bus.src_valid & ready;
`endif
   assign pop           = grant & ~empty;
   assign bus.src_ready = ready;

   always_comb begin
      int idx, last, n;
      grant     = '0;
      lane_act  = '0;
      lane_word = '0;
      last      = 0;
      n         = 0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_SRC) idx = idx - N_SRC;
         for (int j = 0; j < N_SRC; j++) begin
            if (j == idx && cand[j] && n < CDB_W) begin
               grant[j] = 1'b1;
               last     = j;
               for (int l = 0; l < CDB_W; l++) begin
                  if (l == n) begin
                     lane_act[l]  = 1'b1;
                     lane_word[l] = eff[j];
                  end
               end
               n = n + 1;
            end
         end
      end
      rr_next = rr_ptr;
      if (|grant) rr_next = (last == N_SRC-1) ? '0 : SW'(last + 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr  <= '0;
         valid_q <= '0;
         out_q   <= '0;
      end else if (flush) begin
         rr_ptr  <= '0;
         valid_q <= '0;
         out_q   <= '0;
      end else begin
         rr_ptr  <= rr_next;
         valid_q <= lane_act;
         out_q   <= lane_word;
      end
   end

   for (genvar l = 0; l < CDB_W; l++) begin : g_lane
      assign bus.cdb_valid[l]   = valid_q[l];
      assign bus.cdb_tag[l]     = out_q[l].tag;
      assign bus.cdb_value[l]   = out_q[l].value;
      assign bus.cdb_rob_tag[l] = out_q[l].rob;
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, corner sequences, and random traffic
// scored against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;
   localparam int N = 3, L = 2, DEPTH = 4;
`ifdef CDB_ARBITER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [5:0]  tag;
      logic [63:0] val;
      logic [5:0]  rob;
   } ent_t;

   typedef struct {
      logic [2:0] v; logic fl;
      logic [5:0] t0, t1, t2; logic [63:0] v0; logic [5:0] r0;
      logic [1:0] ev; logic [5:0] et0, et1; logic [63:0] ev0; logic [5:0] er0;
   } vec_t;

   logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
   int   errors = 0, checks = 0;

   cdb_arbiter_if #(.N_SRC(N), .CDB_W(L), .PHYS_W(6), .ROB_W(6)) bus ();
   cdb_arbiter #(.N_SRC(N), .CDB_W(L), .PHYS_W(6), .ROB_W(6), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus)
   );

   always #5 clk = ~clk;

   ent_t            mq[N][$];
   int              rr = 0;
   logic [L-1:0]    e_valid;
   logic [L-1:0][5:0]  e_tag, e_rob;
   logic [L-1:0][63:0] e_val;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] m_ready();
      logic [2:0] r;
      for (int i = 0; i < N; i++) r[i] = (mq[i].size() < DEPTH);
      return r;
   endfunction

   function automatic ent_t in_ent(int i);
      return '{tag: bus.src_tag[i], val: bus.src_value[i], rob: bus.src_rob_tag[i]};
   endfunction

   // One clock edge of the reference: scan from rr, take up to L non-empty sources, then queue inputs.
   task automatic model_edge();
      logic [2:0] rdy;
      bit   byp[N];
      int   n, last, i;
      ent_t w;
      rdy = m_ready();
      e_valid = '0; e_tag = '0; e_val = '0; e_rob = '0;
      if (flush) begin
         for (int s = 0; s < N; s++) mq[s].delete();
         rr = 0;
         return;
      end
      n = 0; last = -1;
      for (int s = 0; s < N; s++) byp[s] = 1'b0;
      for (int k = 0; k < N; k++) begin
         i = (rr + k) % N;
         if (n < L && (mq[i].size() > 0 || (BYP && bus.src_valid[i]))) begin
            if (mq[i].size() > 0) w = mq[i].pop_front();
            else begin w = in_ent(i); byp[i] = 1'b1; end
            e_valid[n] = 1'b1; e_tag[n] = w.tag; e_val[n] = w.val; e_rob[n] = w.rob;
            n++; last = i;
         end
      end
      for (int s = 0; s < N; s++)
         if (bus.src_valid[s] && rdy[s] && !byp[s]) mq[s].push_back(in_ent(s));
      if (last >= 0) rr = (last + 1) % N;
   endtask

   task automatic step();
      chk("src_ready", 128'(bus.src_ready), 128'(m_ready()));
      model_edge();
      @(posedge clk); #1;
      chk("cdb_valid", 128'(bus.cdb_valid), 128'(e_valid));
      chk("cdb_tag", 128'(bus.cdb_tag), 128'(e_tag));
      chk("cdb_value", 128'(bus.cdb_value), 128'(e_val));
      chk("cdb_rob_tag", 128'(bus.cdb_rob_tag), 128'(e_rob));
      @(negedge clk);
   endtask

   task automatic drive(logic [2:0] v, logic [5:0] t0, t1, t2, logic [63:0] v0, logic [5:0] r0);
      bus.src_valid   = v;
      bus.src_tag     = {t2, t1, t0};
      bus.src_value   = {64'(t2), 64'(t1), v0};
      bus.src_rob_tag = {t2, t1, r0};
   endtask

   function automatic vec_t mkv(logic [2:0] v, logic fl, logic [5:0] t0, t1, t2, logic [63:0] v0,
                                logic [5:0] r0, logic [1:0] ev, logic [5:0] et0, et1,
                                logic [63:0] ev0, logic [5:0] er0);
      vec_t x;
      x.v = v; x.fl = fl; x.t0 = t0; x.t1 = t1; x.t2 = t2; x.v0 = v0; x.r0 = r0;
      x.ev = ev; x.et0 = et0; x.et1 = et1; x.ev0 = ev0; x.er0 = er0;
      return x;
   endfunction

   vec_t tv[7];
   ent_t seen[$];

   initial begin
      drive(3'b000, 0, 0, 0, 0, 0);
      #2;
      chk("rst_valid", 128'(bus.cdb_valid), 128'(0));
      chk("rst_tag", 128'(bus.cdb_tag), 128'(0));
      chk("rst_value", 128'(bus.cdb_value), 128'(0));
      chk("rst_rob", 128'(bus.cdb_rob_tag), 128'(0));
      chk("rst_ready", 128'(bus.src_ready), 128'(3'b111));
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // src0 single result, flush, then all three sources at once from rr_ptr=0
`ifdef CDB_ARBITER_BYPASS_EN
      tv[0] = mkv(3'b001, 0, 5, 0, 0, 64'h1234, 3, 2'b01, 5, 0, 64'h1234, 3);
      tv[1] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      tv[2] = mkv(3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      tv[3] = mkv(3'b111, 0, 10, 11, 12, 10, 10, 2'b11, 10, 11, 10, 10);
      tv[4] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b01, 12, 0, 12, 12);
      tv[5] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      tv[6] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
`else
      tv[0] = mkv(3'b001, 0, 5, 0, 0, 64'h1234, 3, 2'b00, 0, 0, 0, 0);
      tv[1] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 64'h1234, 3);
      tv[2] = mkv(3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      tv[3] = mkv(3'b111, 0, 10, 11, 12, 10, 10, 2'b00, 0, 0, 0, 0);
      tv[4] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b11, 10, 11, 10, 10);
      tv[5] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b01, 12, 0, 12, 12);
      tv[6] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
`endif
      for (int r = 0; r < 7; r++) begin
         drive(tv[r].v, tv[r].t0, tv[r].t1, tv[r].t2, tv[r].v0, tv[r].r0);
         flush = tv[r].fl;
         step();
         chk($sformatf("tbl%0d_valid", r), 128'(bus.cdb_valid), 128'(tv[r].ev));
         chk($sformatf("tbl%0d_tag0", r), 128'(bus.cdb_tag[0]), 128'(tv[r].et0));
         chk($sformatf("tbl%0d_tag1", r), 128'(bus.cdb_tag[1]), 128'(tv[r].et1));
         chk($sformatf("tbl%0d_val0", r), 128'(bus.cdb_value[0]), 128'(tv[r].ev0));
         chk($sformatf("tbl%0d_rob0", r), 128'(bus.cdb_rob_tag[0]), 128'(tv[r].er0));
      end
      flush = 1'b0;

      // src1 streams six results: each broadcast exactly once, in order
      seen.delete();
      for (int c = 0; c < 9; c++) begin
         if (c < 6) drive(3'b010, 0, 6'(20 + c), 0, 0, 0);
         else       drive(3'b000, 0, 0, 0, 0, 0);
         step();
         for (int l = 0; l < L; l++)
            if (bus.cdb_valid[l]) seen.push_back('{tag: bus.cdb_tag[l], val: 0, rob: 0});
      end
      chk("stream_count", 128'(seen.size()), 128'(6));
      for (int k = 0; k < seen.size() && k < 6; k++)
         chk($sformatf("stream_order%0d", k), 128'(seen[k].tag), 128'(20 + k));

      // fill FIFOs from all sources, then flush with inputs still valid
      for (int c = 0; c < 4; c++) begin
         drive(3'b111, 6'(40 + 3*c), 6'(41 + 3*c), 6'(42 + 3*c), 64'(40 + 3*c), 6'(40 + 3*c));
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(3'b000, 0, 0, 0, 0, 0);
      chk("flush_valid", 128'(bus.cdb_valid), 128'(0));
      chk("flush_ready", 128'(bus.src_ready), 128'(3'b111));
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("post_flush_valid%0d", c), 128'(bus.cdb_valid), 128'(0));
      end

      // asynchronous reset mid-cycle while both lanes are broadcasting
      drive(3'b111, 50, 51, 52, 50, 50);
      step();
      drive(3'b000, 0, 0, 0, 0, 0);
      if (!BYP) step();
      chk("pre_reset_valid", 128'(bus.cdb_valid), 128'(2'b11));
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", 128'(bus.cdb_valid), 128'(0));
      chk("async_rst_tag", 128'(bus.cdb_tag), 128'(0));
      chk("async_rst_value", 128'(bus.cdb_value), 128'(0));
      chk("async_rst_rob", 128'(bus.cdb_rob_tag), 128'(0));
      for (int s = 0; s < N; s++) mq[s].delete();
      rr = 0;
      @(negedge clk);
      reset = 1'b0;
      step();
      step();

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         bus.src_valid = 3'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 3'b110 : 3'b000);
         for (int s = 0; s < N; s++) begin
            bus.src_tag[s]     = 6'($urandom);
            bus.src_value[s]   = {$urandom, $urandom};
            bus.src_rob_tag[s] = 6'($urandom);
         end
         flush = ($urandom_range(0, 39) == 0);
         step();
      end
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
